myadder1_counter_array: RTL and testbench
=========================================

MYADDER1_COUNTER_ARRAY -- requirements
Module: myadder1_counter_array

Interface
REQ-001 Parameter C_NUM_CH, default 4: number of independent counter channels, range 1..32.
REQ-002 Parameter C_WIDTH, default 8: bits per channel counter, range 2..32.
REQ-003 Parameter C_INIT, default 0 (C_WIDTH bits): reset value applied to every channel.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clken  input  1  global clock enable; low freezes all state.
REQ-007 load  input  C_NUM_CH  per-channel load strobe.
REQ-008 incr  input  C_NUM_CH  per-channel increment request.
REQ-009 decr  input  C_NUM_CH  per-channel decrement request.
REQ-010 step  input  C_NUM_CH*C_WIDTH  per-channel step magnitude, channel i at bits [i*C_WIDTH +: C_WIDTH].
REQ-011 load_value  input  C_NUM_CH*C_WIDTH  per-channel load value, same packing.
REQ-012 sat_mode  input  1  0 = wrap modulo 2^C_WIDTH, 1 = saturate at 0 / all-ones.
REQ-013 clr_flags  input  1  clears all sticky range-error flags.
REQ-014 count  output  C_NUM_CH*C_WIDTH  registered counter values, same packing.
REQ-015 is_zero  output  C_NUM_CH  registered, high when channel count == 0.
REQ-016 is_max  output  C_NUM_CH  registered, high when channel count == all-ones.
REQ-017 range_err  output  C_NUM_CH  sticky, set when an operation's true result left [0, 2^C_WIDTH-1].

Function
REQ-018 Channels SHALL be fully independent; only clken, sat_mode, clr_flags, rst are shared.
REQ-019 With clken high, per-channel priority SHALL be: load > (incr xor decr) > hold.
REQ-020 incr and decr both high, or both low, SHALL hold count unchanged.
REQ-021 Increment SHALL compute count+step at C_WIDTH+1 bits; carry out = overflow.
REQ-022 Decrement SHALL compute count-step at C_WIDTH+1 bits; borrow = underflow.
REQ-023 On overflow/underflow with sat_mode=0, count SHALL take the low C_WIDTH bits (wrap).
REQ-024 On overflow with sat_mode=1, count SHALL become all-ones; on underflow, 0.
REQ-025 Overflow or underflow SHALL set range_err for that channel in either mode.
REQ-026 step == 0 SHALL leave count unchanged and never set range_err.
REQ-027 Load SHALL not affect range_err.
REQ-028 Latency: count, is_zero, is_max SHALL reflect an operation one cycle after the sampling edge, mutually consistent every cycle.
REQ-029 is_zero and is_max SHALL be registered from the next-count value, not decoded combinationally from count.
REQ-030 clr_flags SHALL act only when clken is high; same-cycle new error on a channel SHALL win over clear (flag stays 1).
REQ-031 clken low SHALL hold count, is_zero, is_max, range_err, ignoring all other inputs except rst.

Reset
REQ-032 rst SHALL override clken and all other inputs.
REQ-033 On reset every channel count SHALL equal C_INIT, is_zero = (C_INIT==0), is_max = (C_INIT==all-ones), range_err = 0.
REQ-034 Registers SHALL also initialise to reset values at configuration time.
REQ-035 Reset mid-operation SHALL discard any same-cycle load/incr/decr.

Structure
REQ-036 Package myadder1_counter_pkg SHALL hold the mode constants (wrap/saturate) and the parameter range limits.
REQ-037 One channel SHALL be sub-module myadder1_counter_lane, instantiated C_NUM_CH times via generate.
REQ-038 The top level SHALL contain only packing/unpacking and shared-signal fan-out.

Verification
REQ-039 Reset, C_INIT=0xFE: all count=0xFE, is_zero=0, is_max=0, range_err=0; one incr step 1 -> 0xFF, is_max=1.
REQ-040 Ch0 count 0xFA, incr step 0x0A, sat_mode=0 -> 0x04, range_err[0]=1; sat_mode=1 repeat from 0xFA -> 0xFF, range_err[0]=1.
REQ-041 Ch1 count 0x03, decr step 0x05: wrap -> 0xFE; saturate -> 0x00 with is_zero[1]=1; range_err[1]=1 both.
REQ-042 Ch2 load 0x00 with incr, decr high -> 0x00, is_zero=1; incr+decr together next cycle -> hold.
REQ-043 clken low for 3 cycles with incr on all channels: no change; clr_flags with clken low: flags stay; clr_flags with clken high and simultaneous overflow on ch3: range_err[3] stays 1, others clear.
REQ-044 rst asserted in the same cycle as load 0x55 on ch0: ch0 count = C_INIT next cycle.

Source files
------------

// File: rtl/myadder1_counter_pkg.sv
// Shared constants for the myadder1 counter array: overflow mode encoding
// and the supported parameter ranges.
package myadder1_counter_pkg;

  // Behaviour of a channel when an add/subtract leaves the counter range.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned NUM_CH_MIN = 1;
  localparam int unsigned NUM_CH_MAX = 32;
  localparam int unsigned WIDTH_MIN  = 2;
  localparam int unsigned WIDTH_MAX  = 32;

endpackage

// File: rtl/myadder1_counter_lane.sv
// One counter channel: load / step up / step down with wrap or saturate,
// registered zero/max flags and a sticky range-error flag.
module myadder1_counter_lane
  import myadder1_counter_pkg::*;
#(
  parameter int unsigned          C_WIDTH = 8,
  parameter logic [C_WIDTH-1:0]   C_INIT  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clken_i,
  input  logic               load_i,
  input  logic               incr_i,
  input  logic               decr_i,
  input  logic [C_WIDTH-1:0] step_i,
  input  logic [C_WIDTH-1:0] load_value_i,
  input  logic               sat_mode_i,
  input  logic               clr_flags_i,
  output logic [C_WIDTH-1:0] count_o,
  output logic               is_zero_o,
  output logic               is_max_o,
  output logic               range_err_o
);

  localparam logic [C_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic               INIT_ZERO = (C_INIT == '0);
  localparam logic               INIT_MAX  = (C_INIT == ALL_ONES);

  // Declaration values give the reset state at configuration time as well.
  logic [C_WIDTH-1:0] count_q     = C_INIT;
  logic               is_zero_q   = INIT_ZERO;
  logic               is_max_q    = INIT_MAX;
  logic               range_err_q = 1'b0;

  logic [C_WIDTH-1:0] count_d;
  logic               range_err_d;
  logic [C_WIDTH:0]   sum_c;
  logic [C_WIDTH:0]   diff_c;
  logic               err_set_c;

  // Next count and error flag: load beats a single-direction step, otherwise hold.
  always_comb begin
    count_d     = count_q;
    err_set_c   = 1'b0;
    sum_c       = {1'b0, count_q} + {1'b0, step_i};
    diff_c      = {1'b0, count_q} - {1'b0, step_i};
    if (load_i) begin
      count_d = load_value_i;
    end else if (incr_i && !decr_i) begin
      count_d = sum_c[C_WIDTH-1:0];
      if (sum_c[C_WIDTH]) begin
        err_set_c = 1'b1;
        if (sat_mode_i == MODE_SAT) count_d = ALL_ONES;
      end
    end else if (decr_i && !incr_i) begin
      count_d = diff_c[C_WIDTH-1:0];
      if (diff_c[C_WIDTH]) begin
        err_set_c = 1'b1;
        if (sat_mode_i == MODE_SAT) count_d = '0;
      end
    end
    // A new error in the same cycle takes precedence over a clear.
    range_err_d = err_set_c | (range_err_q & ~clr_flags_i);
  end

  // State registers; flags come from the next count so they track count exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= C_INIT;
      is_zero_q   <= INIT_ZERO;
      is_max_q    <= INIT_MAX;
      range_err_q <= 1'b0;
    end else if (clken_i) begin
      count_q     <= count_d;
      is_zero_q   <= (count_d == '0);
      is_max_q    <= (count_d == ALL_ONES);
      range_err_q <= range_err_d;
    end
  end

  assign count_o     = count_q;
  assign is_zero_o   = is_zero_q;
  assign is_max_o    = is_max_q;
  assign range_err_o = range_err_q;

endmodule

// File: rtl/myadder1_counter_array.sv
// Array of independent counter channels; this level only slices the packed
// buses and fans out the shared controls.
module myadder1_counter_array
  import myadder1_counter_pkg::*;
#(
  parameter int unsigned        C_NUM_CH = 4,
  parameter int unsigned        C_WIDTH  = 8,
  parameter logic [C_WIDTH-1:0] C_INIT   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clken,
  input  logic [C_NUM_CH-1:0]         load,
  input  logic [C_NUM_CH-1:0]         incr,
  input  logic [C_NUM_CH-1:0]         decr,
  input  logic [C_NUM_CH*C_WIDTH-1:0] step,
  input  logic [C_NUM_CH*C_WIDTH-1:0] load_value,
  input  logic                        sat_mode,
  input  logic                        clr_flags,
  output logic [C_NUM_CH*C_WIDTH-1:0] count,
  output logic [C_NUM_CH-1:0]         is_zero,
  output logic [C_NUM_CH-1:0]         is_max,
  output logic [C_NUM_CH-1:0]         range_err
);

  // One lane per channel, each on its own C_WIDTH slice of the packed buses.
  for (genvar g = 0; g < int'(C_NUM_CH); g++) begin : g_lane
    myadder1_counter_lane #(
      .C_WIDTH (C_WIDTH),
      .C_INIT  (C_INIT)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .clken_i      (clken),
      .load_i       (load[g]),
      .incr_i       (incr[g]),
      .decr_i       (decr[g]),
      .step_i       (step[g*C_WIDTH +: C_WIDTH]),
      .load_value_i (load_value[g*C_WIDTH +: C_WIDTH]),
      .sat_mode_i   (sat_mode),
      .clr_flags_i  (clr_flags),
      .count_o      (count[g*C_WIDTH +: C_WIDTH]),
      .is_zero_o    (is_zero[g]),
      .is_max_o     (is_max[g]),
      .range_err_o  (range_err[g])
    );
  end

endmodule

// File: tb/tb_myadder1_counter_array.sv
// Bench for myadder1_counter_array: directed vector table plus randomized
// traffic, both checked against an integer-arithmetic reference model.
module tb_myadder1_counter_array;

  localparam int unsigned NCH  = 4;
  localparam int unsigned W    = 8;
  localparam logic [7:0]  INIT = 8'hFE;
  localparam int          MAXV = 255;

  logic        clk = 1'b0;
  logic        rst, clken, sat_mode, clr_flags;
  logic [3:0]  load, incr, decr;
  logic [31:0] step, load_value;
  logic [31:0] count;
  logic [3:0]  is_zero, is_max, range_err;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt [NCH];
  bit m_err [NCH];

  always #5 clk = ~clk;

  myadder1_counter_array #(
    .C_NUM_CH (NCH),
    .C_WIDTH  (W),
    .C_INIT   (INIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .load       (load),
    .incr       (incr),
    .decr       (decr),
    .step       (step),
    .load_value (load_value),
    .sat_mode   (sat_mode),
    .clr_flags  (clr_flags),
    .count      (count),
    .is_zero    (is_zero),
    .is_max     (is_max),
    .range_err  (range_err)
  );

  typedef struct packed {
    logic        rst;
    logic        clken;
    logic [3:0]  load;
    logic [3:0]  incr;
    logic [3:0]  decr;
    logic [31:0] step;
    logic [31:0] lv;
    logic        sat;
    logic        clr;
    int          ch;
    logic [7:0]  e_cnt;
    logic        e_z;
    logic        e_m;
    logic [3:0]  e_err;
  } vec_t;

  vec_t tv [18];

  function automatic vec_t mk(logic r, logic ce, logic [3:0] ld, logic [3:0] inc,
                              logic [3:0] dec, logic [31:0] st, logic [31:0] lv,
                              logic sat, logic clr, int ch, logic [7:0] ec,
                              logic ez, logic em, logic [3:0] ee);
    vec_t v;
    v.rst = r; v.clken = ce; v.load = ld; v.incr = inc; v.decr = dec;
    v.step = st; v.lv = lv; v.sat = sat; v.clr = clr; v.ch = ch;
    v.e_cnt = ec; v.e_z = ez; v.e_m = em; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(string name, int ch, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %0h expected %0h (t=%0t)", name, ch, act, exp, $time);
    end
  endtask

  // Reference: true signed result of each operation, then wrap or clamp.
  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = int'(INIT);
        m_err[c] = 1'b0;
      end
    end else if (clken) begin
      for (int c = 0; c < NCH; c++) begin
        int s;
        int r;
        bit e;
        s = int'(step[c*8 +: 8]);
        e = 1'b0;
        if (load[c]) begin
          m_cnt[c] = int'(load_value[c*8 +: 8]);
        end else if (incr[c] != decr[c]) begin
          r = incr[c] ? m_cnt[c] + s : m_cnt[c] - s;
          if (r > MAXV || r < 0) begin
            e = 1'b1;
            if (sat_mode) r = (r > MAXV) ? MAXV : 0;
            else          r = (r + 256) % 256;
          end
          m_cnt[c] = r;
        end
        m_err[c] = e | (m_err[c] & !clr_flags);
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      chk("count", c, 32'(count[c*8 +: 8]), 32'(m_cnt[c]));
      chk("is_zero", c, 32'(is_zero[c]), 32'(m_cnt[c] == 0));
      chk("is_max", c, 32'(is_max[c]), 32'(m_cnt[c] == MAXV));
      chk("range_err", c, 32'(range_err[c]), 32'(m_err[c]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clken = 1'b1; load = '0; incr = '0; decr = '0;
    step = '0; load_value = '0; sat_mode = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    idle_inputs();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = int'(INIT);
      m_err[c] = 1'b0;
    end
    #1;
    check_all();

    tv[0]  = mk(1,1,4'h0,4'h0,4'h0,32'h0,        32'h0,        0,0, 0,8'hFE,0,0,4'h0);
    tv[1]  = mk(0,1,4'h0,4'h1,4'h0,32'h00000001, 32'h0,        0,0, 0,8'hFF,0,1,4'h0);
    tv[2]  = mk(0,1,4'hF,4'h0,4'h0,32'h0,        32'hF01003FA, 0,0, 0,8'hFA,0,0,4'h0);
    tv[3]  = mk(0,1,4'h0,4'h1,4'h2,32'h0000050A, 32'h0,        0,0, 0,8'h04,0,0,4'h3);
    tv[4]  = mk(0,1,4'h0,4'h0,4'h0,32'h0,        32'h0,        0,1, 1,8'hFE,0,0,4'h0);
    tv[5]  = mk(0,1,4'h3,4'h0,4'h0,32'h0,        32'h000003FA, 0,0, 1,8'h03,0,0,4'h0);
    tv[6]  = mk(0,1,4'h0,4'h1,4'h2,32'h0000050A, 32'h0,        1,0, 1,8'h00,1,0,4'h3);
    tv[7]  = mk(0,1,4'h0,4'h0,4'h0,32'h0,        32'h0,        1,0, 0,8'hFF,0,1,4'h3);
    tv[8]  = mk(0,1,4'h4,4'h4,4'h4,32'h00070000, 32'h0,        0,0, 2,8'h00,1,0,4'h3);
    tv[9]  = mk(0,1,4'h0,4'h4,4'h4,32'h00070000, 32'h0,        0,0, 2,8'h00,1,0,4'h3);
    tv[10] = mk(0,0,4'h0,4'hF,4'h0,32'h01010101, 32'h0,        0,0, 3,8'hF0,0,0,4'h3);
    tv[11] = mk(0,0,4'h0,4'hF,4'h0,32'h01010101, 32'h0,        0,0, 3,8'hF0,0,0,4'h3);
    tv[12] = mk(0,0,4'h0,4'hF,4'h0,32'h01010101, 32'h0,        0,1, 3,8'hF0,0,0,4'h3);
    tv[13] = mk(0,1,4'h0,4'h8,4'h0,32'h20000000, 32'h0,        0,1, 3,8'h10,0,0,4'h8);
    tv[14] = mk(1,1,4'h1,4'h0,4'h0,32'h0,        32'h00000055, 0,0, 0,8'hFE,0,0,4'h0);
    tv[15] = mk(0,1,4'h0,4'h1,4'h2,32'h0,        32'h0,        0,0, 1,8'hFE,0,0,4'h0);
    tv[16] = mk(0,1,4'h0,4'h0,4'h8,32'hFE000000, 32'h0,        0,0, 3,8'h00,1,0,4'h0);
    tv[17] = mk(0,1,4'h0,4'h0,4'h8,32'h01000000, 32'h0,        1,0, 3,8'h00,1,0,4'h8);

    // Directed table: explicit expectations plus the model on every channel.
    for (int i = 0; i < 18; i++) begin
      rst = tv[i].rst; clken = tv[i].clken; load = tv[i].load;
      incr = tv[i].incr; decr = tv[i].decr; step = tv[i].step;
      load_value = tv[i].lv; sat_mode = tv[i].sat; clr_flags = tv[i].clr;
      cycle();
      chk("vec_count", tv[i].ch, 32'(count[tv[i].ch*8 +: 8]), 32'(tv[i].e_cnt));
      chk("vec_zero", tv[i].ch, 32'(is_zero[tv[i].ch]), 32'(tv[i].e_z));
      chk("vec_max", tv[i].ch, 32'(is_max[tv[i].ch]), 32'(tv[i].e_m));
      chk("vec_err", i, 32'(range_err), 32'(tv[i].e_err));
    end

    // Randomized traffic with biased step sizes to hit both range edges.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      clken     = ($urandom_range(0, 4) != 0);
      sat_mode  = 1'($urandom);
      clr_flags = ($urandom_range(0, 7) == 0);
      incr      = 4'($urandom);
      decr      = 4'($urandom);
      for (int c = 0; c < NCH; c++) begin
        load[c] = ($urandom_range(0, 7) == 0);
        load_value[c*8 +: 8] = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       step[c*8 +: 8] = 8'h00;
          1:       step[c*8 +: 8] = 8'($urandom_range(1, 3));
          2:       step[c*8 +: 8] = 8'($urandom);
          default: step[c*8 +: 8] = 8'hFF;
        endcase
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
